cordic_quadrant_fold: RTL and testbench

//  Pipelined CORDIC quadrant pre-/post-stage with valid/ready handshake.
//  - Folds (x,y) into the right half-plane by negating both coordinates, on command or automatically.
//  - Optionally corrects a packed binary angle by +pi.
//  - Sits between sample source and first CORDIC micro-rotation stage; 1-cycle latency, full throughput.
//  - Keeps a saturating count of folded samples.

---
 rtl/cordic_quadrant_fold_if.sv | 33 +++
 rtl/cordic_quadrant_fold.sv | 104 ++++++++++
 tb/tb_cordic_quadrant_fold.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_quadrant_fold_if.sv
// Sample stream into and out of the CORDIC quadrant fold stage.
// The slave modport is the fold stage itself; the master modport is the
// surrounding logic that sources input samples and sinks output samples.
interface cordic_quadrant_fold_if #(
    parameter int B = 14,
    parameter int A = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [B-1:0] in_x;
    logic [B-1:0] in_y;
    logic [A-1:0] in_ang;
    logic         in_has_ang;
    logic [1:0]   in_mode;

    logic         out_valid;
    logic         out_ready;
    logic [B-1:0] out_x;
    logic [B-1:0] out_y;
    logic [A-1:0] out_ang;
    logic         out_fold;
    logic         out_sat;

    modport slave (
        input  in_valid, in_x, in_y, in_ang, in_has_ang, in_mode, out_ready,
        output in_ready, out_valid, out_x, out_y, out_ang, out_fold, out_sat
    );

    modport master (
        output in_valid, in_x, in_y, in_ang, in_has_ang, in_mode, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_ang, out_fold, out_sat
    );
endinterface

// File: rtl/cordic_quadrant_fold.sv
// CORDIC quadrant pre-/post-stage: folds (x,y) into the right half-plane by
// negating both coordinates (forced or when x<0), optionally adds pi to a
// binary angle, and counts folded samples. One output register plus one
// skid register give 1-cycle latency, full throughput and a registered in_ready.
module cordic_quadrant_fold #(
    parameter int B     = 14,
    parameter int A     = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_quadrant_fold_if.slave bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     reflect_cnt
);
    typedef struct packed {
        logic [B-1:0] x;
        logic [B-1:0] y;
        logic [A-1:0] ang;
        logic         fold;
        logic         sat;
    } sample_t;

    localparam logic [B-1:0] MOST_NEG = {1'b1, {(B-1){1'b0}}};
    localparam logic [B-1:0] MOST_POS = {1'b0, {(B-1){1'b1}}};

    sample_t proc;
    sample_t out_r;
    sample_t skid_r;
    logic    out_valid_r;
    logic    skid_full;
    logic    fold;
    logic    sat_x;
    logic    sat_y;
    logic    accept;
    logic    consume;

    // Fold decision and saturating negation of the incoming sample
    always_comb begin
        fold  = (bus.in_mode == 2'b01) | ((bus.in_mode == 2'b10) & bus.in_x[B-1]);
        sat_x = (bus.in_x == MOST_NEG);
        sat_y = (bus.in_y == MOST_NEG);
        proc  = '{x: bus.in_x, y: bus.in_y, ang: bus.in_ang, fold: 1'b0, sat: 1'b0};
        if (fold) begin
            proc.x    = sat_x ? MOST_POS : -bus.in_x;
            proc.y    = sat_y ? MOST_POS : -bus.in_y;
            proc.fold = 1'b1;
            proc.sat  = sat_x | sat_y;
            if (bus.in_has_ang) begin
                proc.ang = {~bus.in_ang[A-1], bus.in_ang[A-2:0]};
            end
        end
    end

    assign accept  = bus.in_valid & ~skid_full;
    assign consume = out_valid_r & bus.out_ready;

    // Output/skid register pair; skid only fills while output is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r       <= '0;
            skid_r      <= '0;
            out_valid_r <= 1'b0;
            skid_full   <= 1'b0;
        end else if (consume) begin
            // in_ready was low whenever skid is full, so no accept collides here
            if (skid_full) begin
                out_r     <= skid_r;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_r <= proc;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept) begin
            if (out_valid_r) begin
                skid_r    <= proc;
                skid_full <= 1'b1;
            end else begin
                out_r       <= proc;
                out_valid_r <= 1'b1;
            end
        end
    end

    // Saturating count of accepted folded samples; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reflect_cnt <= '0;
        end else if (cnt_clr) begin
            reflect_cnt <= '0;
        end else if (accept && fold && (reflect_cnt != '1)) begin
            reflect_cnt <= reflect_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = ~skid_full;
    assign bus.out_valid = out_valid_r;
    assign bus.out_x     = out_r.x;
    assign bus.out_y     = out_r.y;
    assign bus.out_ang   = out_r.ang;
    assign bus.out_fold  = out_r.fold;
    assign bus.out_sat   = out_r.sat;
endmodule

// File: tb/tb_cordic_quadrant_fold.sv
// Bench for cordic_quadrant_fold: table vectors, backpressure, random streaming,
// counter saturation/clear and mid-transfer reset, checked via a scoreboard queue.
module tb_cordic_quadrant_fold;
    typedef struct packed {
        logic [13:0] x;
        logic [13:0] y;
        logic [15:0] ang;
        logic        fold;
        logic        sat;
    } exp_t;

    typedef struct packed {
        logic [1:0]  mode;
        logic [13:0] x;
        logic [13:0] y;
        logic [15:0] ang;
        logic        has;
        exp_t        e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cnt_clr = 1'b0;
    logic [3:0] reflect_cnt;

    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;
    exp_t q[$];
    vec_t vt[9];

    cordic_quadrant_fold_if #(.B(14), .A(16)) bus ();

    cordic_quadrant_fold #(.B(14), .A(16), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cnt_clr     (cnt_clr),
        .reflect_cnt (reflect_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic [13:0] x, input logic [13:0] y,
                                   input logic [15:0] a, input logic h);
        int   xi = $signed(x);
        int   yi = $signed(y);
        int   ai = a;
        bit   f  = (m == 2'd1) || (m == 2'd2 && xi < 0);
        exp_t e;
        e = '{x: x, y: y, ang: a, fold: 1'b0, sat: 1'b0};
        if (f) begin
            e.x    = 14'((xi == -8192) ? 8191 : -xi);
            e.y    = 14'((yi == -8192) ? 8191 : -yi);
            e.sat  = (xi == -8192) || (yi == -8192);
            e.fold = 1'b1;
            if (h) e.ang = 16'((ai + 32768) % 65536);
        end
        return e;
    endfunction

    function automatic vec_t mkv(input int m, input int x, input int y, input int a, input int h,
                                 input int ex, input int ey, input int ea, input int f, input int s);
        vec_t v;
        v.mode = 2'(m);
        v.x = 14'(x);
        v.y = 14'(y);
        v.ang = 16'(a);
        v.has = 1'(h);
        v.e = '{x: 14'(ex), y: 14'(ey), ang: 16'(ea), fold: 1'(f), sat: 1'(s)};
        return v;
    endfunction

    // Drive one sample, wait (bounded) for acceptance, push its expectation.
    // Returns at posedge+1 of the accepting edge with in_valid still high.
    task automatic send(input logic [1:0] m, input logic [13:0] x, input logic [13:0] y,
                        input logic [15:0] a, input logic h, input exp_t e);
        bus.in_valid = 1'b1;
        bus.in_mode = m;
        bus.in_x = x;
        bus.in_y = y;
        bus.in_ang = a;
        bus.in_has_ang = h;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(e);
                if (cnt_clr) exp_cnt = 0;
                else if (e.fold && exp_cnt < 15) exp_cnt++;
                @(posedge clk);
                #1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL accept_timeout got=in_ready_low want=accept t=%0t", $time);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [1:0] m, input logic [13:0] x, input logic [13:0] y,
                              input logic [15:0] a, input logic h);
        send(m, x, y, a, h, model(m, x, y, a, h));
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !bus.out_valid) return;
        end
        check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    // Scoreboard monitor: pops on output transfer, checks hold stability
    exp_t cur;
    exp_t prev;
    bit   held = 0;
    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            cur = '{x: bus.out_x, y: bus.out_y, ang: bus.out_ang, fold: bus.out_fold, sat: bus.out_sat};
            if (held) check("hold_stable", {17'd0, bus.out_valid, cur}, {17'd0, 1'b1, prev});
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 64'(cur), 64'hDEAD_0000_0000_0000);
                end else begin
                    check("out_sample", 64'(cur), 64'(q.pop_front()));
                end
            end
            held = bus.out_valid && !bus.out_ready;
            prev = cur;
        end
    end

    initial begin
        bit done;
        bus.in_valid = 1'b0;
        bus.in_mode = 2'd0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.in_ang = '0;
        bus.in_has_ang = 1'b0;
        bus.out_ready = 1'b1;

        vt[0] = mkv(1, 100, -37, 'h1234, 1, -100, 37, 'h9234, 1, 0);
        vt[1] = mkv(2, -5, 9, 'h0100, 0, 5, -9, 'h0100, 1, 0);
        vt[2] = mkv(2, 5, 9, 'h0100, 1, 5, 9, 'h0100, 0, 0);
        vt[3] = mkv(1, -8192, 0, 'h0000, 1, 8191, 0, 'h8000, 1, 1);
        vt[4] = mkv(3, -8192, -3, 'hABCD, 1, -8192, -3, 'hABCD, 0, 0);
        vt[5] = mkv(0, -1, -1, 'h8001, 1, -1, -1, 'h8001, 0, 0);
        vt[6] = mkv(2, -1, -8192, 'hFFFF, 1, 1, 8191, 'h7FFF, 1, 1);
        vt[7] = mkv(1, 0, 8191, 'h8000, 1, 0, -8191, 'h0000, 1, 0);
        vt[8] = mkv(2, 8191, -8192, 'h4000, 1, 8191, -8192, 'h4000, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_cnt", 64'(reflect_cnt), 64'd0);
        check("rst_out_fields", {18'd0, bus.out_x, bus.out_y, bus.out_ang, bus.out_fold, bus.out_sat}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First vector alone: output visible right after the accepting edge
        send(vt[0].mode, vt[0].x, vt[0].y, vt[0].ang, vt[0].has, vt[0].e);
        check("latency_out_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        drain();

        // Remaining table vectors back to back
        for (int i = 1; i < 9; i++) begin
            send(vt[i].mode, vt[i].x, vt[i].y, vt[i].ang, vt[i].has, vt[i].e);
        end
        drain();
        check("cnt_after_table", 64'(reflect_cnt), 64'(exp_cnt));

        // Backpressure: fill output + skid, hold 3 cycles, then release
        bus.out_ready = 1'b0;
        send_model(2'd1, 14'd11, 14'd22, 16'h0011, 1'b1);
        send_model(2'd0, 14'd33, 14'd44, 16'h0022, 1'b1);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_model(2'(i % 3), 14'(100 * i - 250), 14'(7 * i), 16'(i * 4099), 1'(i % 2));
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Random stream with random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [13:0] rx;
                    logic [13:0] ry;
                    rx = ($urandom_range(0, 7) == 0) ? 14'h2000 : 14'($urandom);
                    ry = ($urandom_range(0, 7) == 0) ? 14'h2000 : 14'($urandom);
                    send_model(2'($urandom_range(0, 3)), rx, ry, 16'($urandom), 1'($urandom_range(0, 1)));
                end
                bus.in_valid = 1'b0;
                done = 1;
            end
            begin
                repeat (400) begin
                    if (done) break;
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check("cnt_after_stream", 64'(reflect_cnt), 64'(exp_cnt));

        // Counter: clear beats a folded accept, saturation at 15
        cnt_clr = 1'b1;
        send_model(2'd1, 14'd5, 14'd5, 16'h0000, 1'b0);
        cnt_clr = 1'b0;
        check("cnt_clr_prio", 64'(reflect_cnt), 64'd0);
        for (int i = 0; i < 20; i++) begin
            send_model(2'd1, 14'(i + 1), 14'(-i), 16'(i), 1'b1);
        end
        bus.in_valid = 1'b0;
        check("cnt_saturate", 64'(reflect_cnt), 64'd15);
        cnt_clr = 1'b1;
        send_model(2'd2, 14'h3FFF, 14'd1, 16'h1000, 1'b1);
        cnt_clr = 1'b0;
        bus.in_valid = 1'b0;
        check("cnt_clr_sat", 64'(reflect_cnt), 64'd0);
        drain();

        // Reset with both registers full
        bus.out_ready = 1'b0;
        send_model(2'd1, 14'd77, 14'd88, 16'h0123, 1'b1);
        send_model(2'd1, 14'd99, 14'd66, 16'h0456, 1'b1);
        bus.in_valid = 1'b0;
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_stale_out", 64'(bus.out_valid), 64'd0);
        check("arst_cnt", 64'(reflect_cnt), 64'd0);
        send(vt[6].mode, vt[6].x, vt[6].y, vt[6].ang, vt[6].has, vt[6].e);
        drain();
        check("final_queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end
endmodule
